// File: rtl/hdd_sector_pkg.sv
// Shared types and constants for the HDD sector server.
package hdd_sector_pkg;

    // Bytes per sector (a power of two); the sector buffer is addressed by offset.
    localparam int SECTOR_BYTES = 512;
    localparam int OFFS_W       = $clog2(SECTOR_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_BUF,
        WB_ADDR,
        WB_DATA,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/hdd_req_edge.sv
// Rising-edge detector for a read/write request pair. Read wins when both
// rise together; edges seen while the consumer is busy are dropped.
module hdd_req_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_read,
    input  logic i_write,
    input  logic i_busy,
    output logic o_rd_start,
    output logic o_wr_start
);

    logic r_read_q;
    logic r_write_q;
    logic w_rd_edge;
    logic w_wr_edge;

    // Remember the previous request levels so that a rise can be seen.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_q  <= 1'b0;
            r_write_q <= 1'b0;
        end else begin
            r_read_q  <= i_read;
            r_write_q <= i_write;
        end
    end

    assign w_rd_edge  = i_read  & ~r_read_q;
    assign w_wr_edge  = i_write & ~r_write_q;
    assign o_rd_start = w_rd_edge & ~i_busy;
    assign o_wr_start = w_wr_edge & ~w_rd_edge & ~i_busy;

endmodule

// File: rtl/hdd_sector_server.sv
// Moves one sector between the HDD controller's sector buffer and a
// byte-wide image store, one byte per store handshake.
module hdd_sector_server
    import hdd_sector_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       hdd_sector,
    input  logic              hdd_read,
    input  logic              hdd_write,
    output logic              hdd_mounted,
    output logic              hdd_protect,
    output logic [OFFS_W-1:0] buf_addr,
    output logic [7:0]        buf_di,
    input  logic [7:0]        buf_do,
    output logic              buf_we,
    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [15:0]       img_blocks,
    output logic [ADDR_W-1:0] st_addr,
    output logic              st_req,
    output logic              st_we,
    output logic [7:0]        st_wdata,
    input  logic [7:0]        st_rdata,
    input  logic              st_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                CNT_W     = $clog2(ACK_TIMEOUT + 1);
    // The request cycle itself counts as the first waited cycle.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [OFFS_W-1:0] OFFS_LAST = OFFS_W'(SECTOR_BYTES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_sector;
    logic [OFFS_W-1:0]   r_offset;
    logic [7:0]          r_rdata;
    logic [7:0]          r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic                r_mounted;
    logic                r_protect;
    logic                w_rd_start;
    logic                w_wr_start;
    logic                w_accept;
    logic                w_reject;
    logic                w_last;
    logic                w_timeout;
    logic                w_advance;
    logic [15+OFFS_W:0]  w_addr_full;

    hdd_req_edge u_edge (
        .clk        (clk_sys),
        .reset      (reset),
        .i_read     (hdd_read),
        .i_write    (hdd_write),
        .i_busy     (r_state != IDLE),
        .o_rd_start (w_rd_start),
        .o_wr_start (w_wr_start)
    );

    assign w_accept  = w_rd_start | w_wr_start;
    assign w_reject  = ~img_mounted | (hdd_sector >= img_blocks) | (w_wr_start & img_readonly);
    assign w_last    = (r_offset == OFFS_LAST);
    assign w_timeout = ~st_ack & (r_cnt >= CNT_LAST);

    // Zero-extended {sector, offset} cannot overflow when ADDR_W >= 16 + OFFS_W.
    assign w_addr_full = {r_sector, r_offset};
    assign st_addr     = ADDR_W'(w_addr_full);
    assign buf_addr    = r_offset;
    assign buf_di      = r_rdata;
    assign st_wdata    = r_wdata;
    assign err         = r_err;
    assign hdd_mounted = r_mounted;
    assign hdd_protect = r_protect;

    // State register; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode.
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        st_req    = 1'b0;
        st_we     = 1'b0;
        buf_we    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    if (w_reject) begin
                        w_next = DONE;
                    end else if (w_rd_start) begin
                        w_next = RD_REQ;
                    end else begin
                        w_next = WB_ADDR;
                    end
                end
            end
            RD_REQ: begin
                st_req = 1'b1;
                w_next = RD_WAIT;
            end
            RD_WAIT: begin
                st_req = 1'b1;
                if (st_ack) begin
                    w_next = RD_BUF;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            RD_BUF: begin
                buf_we = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next    = RD_REQ;
                    w_advance = 1'b1;
                end
            end
            WB_ADDR: w_next = WB_DATA;
            WB_DATA: w_next = WR_REQ;
            WR_REQ: begin
                st_req = 1'b1;
                st_we  = 1'b1;
                w_next = WR_WAIT;
            end
            WR_WAIT: begin
                st_req = 1'b1;
                st_we  = 1'b1;
                if (st_ack) begin
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_next    = WB_ADDR;
                        w_advance = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    // Request latch, byte offset, data capture, ack timer and status flags.
    // NOTE: all datapath registers are reset so every output reads 0 right after reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sector  <= '0;
            r_offset  <= '0;
            r_rdata   <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_mounted <= 1'b0;
            r_protect <= 1'b0;
        end else begin
            r_mounted <= img_mounted;
            r_protect <= img_readonly;
            if (r_state == IDLE && w_accept) begin
                r_sector <= hdd_sector;
                r_offset <= '0;
                r_err    <= w_reject;
            end
            if (w_advance) begin
                r_offset <= r_offset + OFFS_W'(1);
            end
            if (r_state == RD_WAIT && st_ack) begin
                r_rdata <= st_rdata;
            end
            if (r_state == WB_DATA) begin
                r_wdata <= buf_do;
            end
            // The timer restarts on each new request and runs while it is held.
            if (r_state == RD_REQ || r_state == WR_REQ) begin
                r_cnt <= CNT_W'(1);
            end else if (st_req) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == RD_WAIT || r_state == WR_WAIT) && w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdd_sector_server.sv
// Directed bench for hdd_sector_server: vector table plus corner sequences.
module tb_hdd_sector_server;
    import hdd_sector_pkg::*;

    localparam int ADDR_W = 25;
    localparam int ACK_TO = 15;

    logic              clk;
    logic              reset;
    logic [15:0]       hdd_sector;
    logic              hdd_read;
    logic              hdd_write;
    logic              hdd_mounted;
    logic              hdd_protect;
    logic [OFFS_W-1:0] buf_addr;
    logic [7:0]        buf_di;
    logic [7:0]        buf_do;
    logic              buf_we;
    logic              img_mounted;
    logic              img_readonly;
    logic [15:0]       img_blocks;
    logic [ADDR_W-1:0] st_addr;
    logic              st_req;
    logic              st_we;
    logic [7:0]        st_wdata;
    logic [7:0]        st_rdata;
    logic              st_ack;
    logic              busy;
    logic              done;
    logic              err;

    hdd_sector_server #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk_sys(clk), .reset(reset), .hdd_sector(hdd_sector),
        .hdd_read(hdd_read), .hdd_write(hdd_write),
        .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
        .buf_addr(buf_addr), .buf_di(buf_di), .buf_do(buf_do), .buf_we(buf_we),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_blocks(img_blocks),
        .st_addr(st_addr), .st_req(st_req), .st_we(st_we), .st_wdata(st_wdata),
        .st_rdata(st_rdata), .st_ack(st_ack),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sector buffer RAM: synchronous read, one cycle latency.
    logic [7:0] buf_mem [SECTOR_BYTES];
    logic       preload_req = 1'b0;
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < SECTOR_BYTES; i++) buf_mem[i] <= 8'(i);
        end else if (buf_we) begin
            buf_mem[buf_addr] <= buf_di;
        end
        buf_do <= buf_mem[buf_addr];
    end

    // Image store: acks in the second cycle of a request; logs every access.
    logic              ack_en    = 1'b1;
    int                stale_tok = 0;
    int                acc_mark  = 0;
    logic [ADDR_W-1:0] wr_base   = '0;
    int                n_acc     = 0;
    int                wr_mism   = 0;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    initial begin
        int req_age;
        int stale_seen;
        logic [ADDR_W-1:0] exp_a;
        st_ack = 1'b0; st_rdata = 8'h00; req_age = 0; stale_seen = 0;
        first_addr = '0; last_addr = '0;
        forever begin
            @(posedge clk); #1;
            st_ack = 1'b0;
            if (!st_req) req_age = 0;
            else if (ack_en) req_age++;
            if (stale_tok != stale_seen) begin
                stale_seen = stale_tok;
                st_ack     = 1'b1;
                st_rdata   = 8'hEE;
            end else if (req_age == 2) begin
                req_age = 0;
                st_ack  = 1'b1;
                if (n_acc == acc_mark) first_addr = st_addr;
                last_addr = st_addr;
                if (st_we) begin
                    exp_a = wr_base + ADDR_W'(n_acc - acc_mark);
                    if (st_addr !== exp_a || st_wdata !== 8'(n_acc - acc_mark)) wr_mism++;
                end else begin
                    st_rdata = st_addr[7:0] ^ 8'h5A;
                end
                n_acc++;
            end
        end
    end

    // Output event counters sampled mid-cycle.
    int n_bufwe = 0, n_done = 0, n_req_cyc = 0, n_we_cyc = 0;
    always @(negedge clk) begin
        if (buf_we) n_bufwe++;
        if (done)   n_done++;
        if (st_req) n_req_cyc++;
        if (st_we)  n_we_cyc++;
    end

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (lat >= budget) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, output logic ok);
        int k;
        k  = 0;
        ok = 1'b1;
        while (n_bufwe < target) begin
            @(posedge clk); #1;
            k++;
            if (k >= budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    typedef struct {
        logic              is_wr;
        logic [15:0]       sector;
        logic              mounted;
        logic              ro;
        logic [15:0]       blocks;
        logic              exp_err;
        int                exp_lat;
        int                exp_acc;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, b_done, b_bufwe, b_acc, b_mism, b_req, b_we, mism;
        logic ok;
        logic [ADDR_W-1:0] a;
        logic [7:0] eb;

        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b_done, b_bufwe, b_acc, b_mism, b_req, b_we, mism;
        logic ok;
        logic [ADDR_W-1:0] a;
        logic [7:0] eb;

        vecs[0] = '{1'b0, 16'd3,      1'b1, 1'b0, 16'd16,     1'b0, 1537, 512, 25'h0000600, 25'h00007FF};
        vecs[1] = '{1'b1, 16'h0010,   1'b1, 1'b0, 16'h0040,   1'b0, 2049, 512, 25'h0002000, 25'h00021FF};
        vecs[2] = '{1'b1, 16'd2,      1'b1, 1'b1, 16'd16,     1'b1, 1,    0,   25'h0,       25'h0};
        vecs[3] = '{1'b0, 16'd16,     1'b1, 1'b0, 16'd16,     1'b1, 1,    0,   25'h0,       25'h0};
        vecs[4] = '{1'b0, 16'd0,      1'b0, 1'b0, 16'd16,     1'b1, 1,    0,   25'h0,       25'h0};
        vecs[5] = '{1'b0, 16'hFFFE,   1'b1, 1'b0, 16'hFFFF,   1'b0, 1537, 512, 25'h1FFFC00, 25'h1FFFDFF};
        vecs[6] = '{1'b0, 16'd0,      1'b1, 1'b1, 16'd16,     1'b0, 1537, 512, 25'h0000000, 25'h00001FF};

        reset = 1'b1; hdd_sector = 16'd0; hdd_read = 1'b0; hdd_write = 1'b0;
        img_mounted = 1'b1; img_readonly = 1'b0; img_blocks = 16'd16;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, err, st_req, st_we, buf_we, hdd_mounted, hdd_protect}, 32'h0);
        check("rst_st_addr", st_addr, 32'h0);
        check("rst_buf", {buf_addr, buf_di, st_wdata}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mounted_after_rst", hdd_mounted, 32'h1);

        // Table-driven requests.
        for (int v = 0; v < 7; v++) begin
            img_mounted = vecs[v].mounted; img_readonly = vecs[v].ro; img_blocks = vecs[v].blocks;
            hdd_sector  = vecs[v].sector;
            if (vecs[v].is_wr) begin
                preload_req = 1'b1;
                @(posedge clk); #1;
                preload_req = 1'b0;
            end
            @(posedge clk); #1;
            acc_mark = n_acc; wr_base = vecs[v].exp_first;
            b_done = n_done; b_bufwe = n_bufwe; b_acc = n_acc; b_mism = wr_mism;
            if (vecs[v].is_wr) hdd_write = 1'b1;
            else               hdd_read  = 1'b1;
            wait_done(vecs[v].exp_lat + 50, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            hdd_read = 1'b0; hdd_write = 1'b0;
            @(posedge clk); #1;
            check($sformatf("v%0d_idle_after", v), {done, busy}, 32'h0);
            check($sformatf("v%0d_done_count", v), n_done - b_done, 32'd1);
            check($sformatf("v%0d_store_acc", v), n_acc - b_acc, vecs[v].exp_acc);
            check($sformatf("v%0d_buf_we", v), n_bufwe - b_bufwe,
                  (!vecs[v].is_wr && vecs[v].exp_acc > 0) ? 32'd512 : 32'd0);
            if (vecs[v].exp_acc > 0) begin
                check($sformatf("v%0d_first_addr", v), first_addr, vecs[v].exp_first);
                check($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last);
                if (vecs[v].is_wr) begin
                    check($sformatf("v%0d_wr_seq", v), wr_mism - b_mism, 32'd0);
                end else begin
                    mism = 0;
                    for (int i = 0; i < SECTOR_BYTES; i++) begin
                        a  = vecs[v].exp_first + ADDR_W'(i);
                        eb = a[7:0] ^ 8'h5A;
                        if (buf_mem[i] !== eb) mism++;
                    end
                    check($sformatf("v%0d_buf_data", v), mism, 32'd0);
                    check($sformatf("v%0d_buf0", v), buf_mem[0], vecs[v].exp_first[7:0] ^ 8'h5A);
                end
            end
        end

        // Read and write rise together; a second read edge mid-transfer is ignored.
        img_mounted = 1'b1; img_readonly = 1'b0; img_blocks = 16'd16; hdd_sector = 16'd5;
        b_done = n_done; b_bufwe = n_bufwe; b_acc = n_acc; b_we = n_we_cyc;
        hdd_read = 1'b1; hdd_write = 1'b1;
        wait_bytes(b_bufwe + 50, 400, ok);
        check("both_progress50", ok, 32'h1);
        hdd_read = 1'b0; hdd_write = 1'b0;
        wait_bytes(b_bufwe + 100, 400, ok);
        check("both_progress100", ok, 32'h1);
        hdd_read = 1'b1;
        wait_done(2000, lat);
        check("both_done_seen", lat > 0, 32'h1);
        repeat (40) @(posedge clk);
        #1;
        check("both_single_done", n_done - b_done, 32'd1);
        check("both_no_write", n_we_cyc - b_we, 32'd0);
        check("both_bytes", n_bufwe - b_bufwe, 32'd512);
        check("both_acc", n_acc - b_acc, 32'd512);
        check("both_idle", {busy, st_req, err}, 32'h0);
        hdd_read = 1'b0;
        @(posedge clk); #1;

        // Store never acks: request held for ACK_TO cycles, then error.
        ack_en = 1'b0; hdd_sector = 16'd1;
        b_done = n_done; b_req = n_req_cyc; b_bufwe = n_bufwe;
        hdd_read = 1'b1;
        wait_done(200, lat);
        check("to_latency", lat, 32'd16);
        check("to_err", err, 32'h1);
        check("to_req_cycles", n_req_cyc - b_req, ACK_TO);
        check("to_no_buf_we", n_bufwe - b_bufwe, 32'd0);
        @(posedge clk); #1;
        check("to_idle", {busy, done, st_req}, 32'h0);
        hdd_read = 1'b0; ack_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        hdd_sector = 16'd2; acc_mark = n_acc;
        hdd_read = 1'b1;
        wait_done(1600, lat);
        check("after_to_latency", lat, 32'd1537);
        check("after_to_err", err, 32'h0);
        check("after_to_first", first_addr, 32'h400);
        hdd_read = 1'b0;
        @(posedge clk); #1;

        // Protection flips mid-write: the write still completes.
        img_readonly = 1'b0; hdd_sector = 16'd1;
        preload_req = 1'b1;
        @(posedge clk); #1;
        preload_req = 1'b0;
        acc_mark = n_acc; wr_base = 25'h200; b_mism = wr_mism;
        hdd_write = 1'b1;
        fork
            begin
                repeat (100) @(posedge clk);
                #1 img_readonly = 1'b1;
            end
        join_none
        wait_done(2100, lat);
        check("ro_mid_latency", lat, 32'd2049);
        check("ro_mid_err", err, 32'h0);
        check("ro_mid_seq", wr_mism - b_mism, 32'd0);
        check("ro_mid_protect", hdd_protect, 32'h1);
        hdd_write = 1'b0; img_readonly = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a read.
        hdd_sector = 16'd4; b_bufwe = n_bufwe;
        hdd_read = 1'b1;
        wait_bytes(b_bufwe + 200, 800, ok);
        check("rstmid_progress", ok, 32'h1);
        reset = 1'b1; hdd_read = 1'b0;
        b_done = n_done;
        @(posedge clk); #1;
        check("rstmid_outputs", {st_req, buf_we, busy, done, err, hdd_mounted}, 32'h0);
        stale_tok++;
        @(posedge clk); #1;
        reset = 1'b0;
        b_bufwe = n_bufwe; b_acc = n_acc;
        @(posedge clk); #1;
        check("rstmid_mounted", hdd_mounted, 32'h1);
        stale_tok++;
        repeat (6) @(posedge clk);
        #1;
        check("rstmid_no_done", n_done - b_done, 32'd0);
        check("rstmid_stale_ignored", {n_bufwe - b_bufwe, n_acc - b_acc}, 32'h0);
        check("rstmid_idle", {busy, st_req, err}, 32'h0);
        img_mounted = 1'b0;
        @(posedge clk); #1;
        check("unmount_follow", hdd_mounted, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdd_sector_server.md
Name: hdd_sector_server

Overview:
- Host-side responder for the slot-7 HDD controller's sector protocol.
- The controller raises hdd_read or hdd_write with a 16-bit sector number. This block moves that 512-byte block between the controller's sector buffer RAM and a byte-wide backing image store, then signals completion.
- Drives mounted/protect status back to the controller.
- Sits at top level between the HDD controller and the image store (SDRAM/sim file model).

Parameters:
- SECTOR_BYTES, 512, bytes per sector; must be a power of 2; buffer address width = log2(SECTOR_BYTES).
- ADDR_W, 25, width of the backing-store byte address.
- ACK_TIMEOUT, 1023, max cycles to wait for st_ack per byte before aborting with error.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hdd_sector  in  16  sector number requested by the controller.
- hdd_read  in  1  read request level; rising edge starts an image->buffer transfer.
- hdd_write  in  1  write request level; rising edge starts a buffer->image transfer.
- hdd_mounted  out  1  registered copy of img_mounted.
- hdd_protect  out  1  registered copy of img_readonly.
- buf_addr  out  9  sector buffer byte address.
- buf_di  out  8  data written into the sector buffer.
- buf_do  in  8  sector buffer read data; valid 1 cycle after buf_addr.
- buf_we  out  1  sector buffer write strobe.
- img_mounted  in  1  image present.
- img_readonly  in  1  image write-protected.
- img_blocks  in  16  image size in sectors.
- st_addr  out  ADDR_W  byte address = hdd_sector*SECTOR_BYTES + offset.
- st_req  out  1  store request; held until st_ack.
- st_we  out  1  1 = write, 0 = read; stable while st_req is high.
- st_wdata  out  8  store write data.
- st_rdata  in  8  store read data; valid in the st_ack cycle.
- st_ack  in  1  one-cycle completion of the current byte access.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at the end of every accepted request, success or error.
- err  out  1  status of the last request; held until the next request is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; edge-detect registers 0.
- Edge detection: rd_edge = hdd_read & ~hdd_read_q; wr_edge likewise. If both edges occur in the same cycle, read wins and the write edge is dropped.
- Edges arriving while busy are ignored; they are not queued.
- Request latch: on an accepted edge in IDLE, latch hdd_sector, clear err, set busy, clear offset to 0.
- Reject conditions, checked in IDLE on the accepted edge. If any holds, go straight to DONE with err=1 and perform no store or buffer access:
  - ~img_mounted;
  - hdd_sector >= img_blocks;
  - write request while img_readonly is 1.
- Read path states:
  - RD_REQ: assert st_req, st_we=0, st_addr = {sector, offset}.
  - RD_WAIT: on st_ack, capture st_rdata, drop st_req, go to RD_BUF.
  - RD_BUF: buf_we=1 for 1 cycle with buf_addr=offset and buf_di=captured byte.
  - Then: if offset == SECTOR_BYTES-1 go to DONE; else offset+1 and back to RD_REQ.
- Write path states:
  - WB_ADDR: present buf_addr=offset.
  - WB_DATA: capture buf_do into st_wdata.
  - WR_REQ / WR_WAIT: st_req=1, st_we=1; on st_ack drop st_req.
  - Then advance offset as on the read path.
- st_req deasserts in the same cycle st_ack is sampled high. Minimum 1 idle cycle between consecutive st_req assertions.
- Timeout: a cycle counter resets on every st_req rising edge. If it reaches ACK_TIMEOUT without st_ack, drop st_req, set err=1, go to DONE. Buffer bytes already transferred are left as-is.
- DONE: 1 cycle, done=1 and busy=0, then IDLE.
- Minimum transfer time with zero-wait ack:
  - read: 3 cycles/byte, 1536 + 2 total;
  - write: 4 cycles/byte, 2048 + 2 total.
- Address arithmetic: st_addr = zero-extend(sector) << log2(SECTOR_BYTES) | offset. A sector of 0xFFFF must not overflow ADDR_W=25.
- Reset mid-transfer aborts immediately: st_req and buf_we go low on the next edge, no done pulse. A store ack that arrives after the abort is ignored.
- hdd_mounted and hdd_protect are registered every cycle, independent of state.
- img_readonly changing mid-write does not abort the write; protection is checked only at acceptance.

Decomposition:
- Package hdd_sector_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, RD_BUF, WB_ADDR, WB_DATA, WR_REQ, WR_WAIT, DONE);
  - SECTOR_BYTES and offset-width localparam.
- Sub-module hdd_req_edge: 2-input edge detector with read priority and busy masking. Small, but it is reused by the floppy path later.
- FSM and datapath stay in one module.

Test Plan:
- Read sector 3, img_blocks=16, store returns byte = addr[7:0]^0x5A with 2-cycle ack latency -> 512 buf_we pulses; buf[0]=0x5A, buf[511]=0xA5; st_addr first/last = 0x600/0x7FF; done=1, err=0.
- Write sector 0x0010 with buffer preloaded with index[7:0] -> 512 store writes; st_addr 0x2000..0x21FF; st_wdata[k]=k[7:0]; done=1, err=0.
- hdd_write rising while img_readonly=1 -> no st_req, done pulses 2 cycles after the edge, err=1; hdd_read of sector 16 with img_blocks=16 -> same reject.
- hdd_read and hdd_write rise in the same cycle -> read transfer only (st_we never 1); a second hdd_read edge at byte 100 is ignored; exactly 1 done.
- st_ack never returned with ACK_TIMEOUT=15 -> st_req drops at cycle 15, err=1, done pulse, back to IDLE; the next read completes normally.
- reset asserted at byte 200 of a read -> outputs 0 next cycle, no done; a stale st_ack is ignored; hdd_mounted follows img_mounted within 1 cycle after reset.
